// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared encodings for the criscv memory-bus responder.
// Contents: size codes, responder FSM state enum, default address map
// constants and small lane-steering helpers used by mem_resp.
package mem_resp_pkg;

  // Bus size encodings; 2'd3 is accepted and handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Default address map: 8 KB RAM at 0, port register just above it.
  localparam int          DEF_DEPTH_WORDS = 2048;
  localparam logic [31:0] DEF_PORT_ADDR   = 32'h0000_2000;
  localparam logic [31:0] RAM_BASE        = 32'h0000_0000;

  // Byte enables for an access. Half uses address[1] only and word ignores
  // address[1:0], so misaligned requests are truncated to the natural lane.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b1111;
    case (sz)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Right-shift (in bits) that moves the addressed lane down to bit 0.
  function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] a);
    logic [4:0] sh;
    sh = 5'd0;
    case (sz)
      SZ_BYTE: sh = {a, 3'b000};
      SZ_HALF: sh = {a[1], 4'b0000};
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

  // Zero-extension mask for the loaded value.
  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    case (sz)
      SZ_BYTE: m = 32'h0000_00FF;
      SZ_HALF: m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: single-port DEPTH_WORDS x 32 synchronous RAM, 4 byte enables.
// Ports: mclk_i clock; en_i access strobe; we_i write (else read); be_i byte
// enables; addr_i word address; wdata_i lane-steered data; rdata_o registered read.
module mem_resp_ram #(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic                           mclk_i,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [3:0]                     be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Contents are deliberately not reset; only the read register updates on reads.
  always_ff @(posedge mclk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// mem_resp: bus target for the criscv core -- 8 KB RAM plus one output port register.
// Ports: mclk/reset (sync, active-low); address/rw_req/rw/size/write_data request side;
// read_data/data_valid response side; port pin; err misalignment flag.
// Build option: MEM_RESP_ALIGN_CHECK_EN enables misalignment detection (err); otherwise
// misaligned addresses are truncated and err is tied 0.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter logic [31:0] PORT_ADDR   = DEF_PORT_ADDR
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        rw_req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        data_valid,
  output logic        port,
  output logic        err
);

  localparam int          WAW       = $clog2(DEPTH_WORDS);
  localparam int          BAW       = WAW + 2;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  // Request latched in IDLE; held stable for the rest of the transaction.
  state_e      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        rw_q;
  logic [31:0] wdata_q;

  // Registered outputs.
  logic [31:0] read_data_q;
  logic        data_valid_q;
  logic        port_q;

  // Decode of the latched request.
  logic [31:0] ram_off;
  logic        in_ram;
  logic        in_port;
  logic        misal;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] ram_load;
  logic [31:0] resp_data_d;
  logic        ram_en;
  logic        port_wr;

  assign ram_off = addr_q - RAM_BASE;
  assign in_ram  = (ram_off < RAM_BYTES);
  assign in_port = (addr_q == PORT_ADDR);
  assign be      = byte_en(size_q, addr_q[1:0]);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign misal = ((size_q == SZ_HALF) && addr_q[0]) ||
                 (size_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // Replicate store data across lanes; byte enables pick the live lane.
  always_comb begin
    lane_wdata = wdata_q;
    case (size_q)
      SZ_BYTE: lane_wdata = {4{wdata_q[7:0]}};
      SZ_HALF: lane_wdata = {2{wdata_q[15:0]}};
      default: lane_wdata = wdata_q;
    endcase
  end

  // RAM is touched only on the ACCESS edge. Gating with reset means a store
  // caught by reset at that edge never reaches the array.
  assign ram_en  = (state_q == ST_ACCESS) && reset && in_ram && !misal;
  assign port_wr = (state_q == ST_ACCESS) && rw_q && in_port && be[0] && !misal;

  mem_resp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .mclk_i  (mclk),
    .en_i    (ram_en),
    .we_i    (rw_q),
    .be_i    (be),
    .addr_i  (ram_off[BAW-1:2]),
    .wdata_i (lane_wdata),
    .rdata_o (ram_rdata)
  );

  assign ram_load = (ram_rdata >> lane_shift(size_q, addr_q[1:0])) & size_mask(size_q);

  // Load result chosen on RESP entry. The port cannot change between ACCESS
  // and RESP of a read, so reading port_q here matches the ACCESS-time value.
  always_comb begin
    resp_data_d = 32'h0;
    if (misal) begin
      resp_data_d = 32'h0;
    end else if (in_ram) begin
      resp_data_d = ram_load;
    end else if (in_port) begin
      resp_data_d = {31'b0, port_q};
    end
  end

`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge mclk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state_q == ST_RESP) begin
      // Tracks data_valid: set on RESP entry, cleared on exit.
      if (!data_valid_q) begin
        err_q <= misal;
      end else if (!rw_req) begin
        err_q <= 1'b0;
      end
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      data_valid_q <= 1'b0;
      read_data_q  <= 32'h0;
      port_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rw_req) begin
            addr_q  <= address;
            size_q  <= size;
            rw_q    <= rw;
            wdata_q <= write_data;
            state_q <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (port_wr) begin
            port_q <= wdata_q[0];
          end
          state_q <= ST_RESP;
        end

        ST_RESP: begin
          // First RESP edge publishes the result (RAM read data is valid now);
          // later edges only wait for the core to drop rw_req.
          if (!data_valid_q) begin
            data_valid_q <= 1'b1;
            if (!rw_q) begin
              read_data_q <= resp_data_d;
            end
          end else if (!rw_req) begin
            data_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          data_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign read_data  = read_data_q;
  assign data_valid = data_valid_q;
  assign port       = port_q;

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: randomized + directed bench for mem_resp with a byte-array reference model.
// A driver issues four-phase transactions and pushes expected responses; a monitor
// pops and compares on each rising data_valid.
module tb_mem_resp;

  localparam logic [31:0] PORT_A = 32'h0000_2000;
  localparam int          RAM_B  = 8192;

  logic        mclk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        rw_req;
  logic        rw;
  logic [1:0]  size;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        data_valid;
  logic        port;
  logic        err;

  mem_resp dut (
    .mclk       (mclk),
    .reset      (reset),
    .address    (address),
    .rw_req     (rw_req),
    .rw         (rw),
    .size       (size),
    .write_data (write_data),
    .read_data  (read_data),
    .data_valid (data_valid),
    .port       (port),
    .err        (err)
  );

  always #5 mclk = ~mclk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  logic [7:0]  mb [RAM_B];
  logic        m_port;
  logic [31:0] m_last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_misal(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    return ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Apply a transaction to the model; returns the expected response.
  function automatic exp_t m_apply(input logic w, input logic [1:0] sz,
                                   input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int n;
    int base;
    logic [31:0] v;
    n    = m_nbytes(sz);
    base = int'(a & ~(32'(n) - 32'd1));
    e.er = m_misal(a, sz);
    if (w) begin
      if (!e.er) begin
        if (a == PORT_A) begin
          m_port = wd[0];
        end else if (a < RAM_B) begin
          for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
        end
      end
    end else begin
      v = 32'h0;
      if (!e.er) begin
        if (a == PORT_A) begin
          v = {31'b0, m_port};
        end else if (a < RAM_B) begin
          for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base + i];
        end
      end
      m_last_rd = v;
    end
    e.rd = m_last_rd;
    return e;
  endfunction

  // Monitor: compare every response as data_valid rises.
  logic dv_prev = 1'b0;
  always @(negedge mclk) begin
    exp_t e;
    if (data_valid === 1'b1 && dv_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {31'b0, data_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_read_data", read_data, e.rd);
        chk("resp_err", {31'b0, err}, {31'b0, e.er});
      end
    end
    dv_prev = data_valid;
  end

  // One transaction, entered and left at a negedge. Request fields are
  // scrambled after acceptance to show the DUT ignores them.
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, output logic [31:0] rd_got);
    exp_t e;
    e = m_apply(w, sz, a, wd);
    exp_q.push_back(e);
    rw_req = 1'b1; rw = w; size = sz; address = a; write_data = wd;
    @(posedge mclk);                     // E0
    @(negedge mclk);
    address = 32'($urandom_range(0, 1023)); rw = ~w;
    write_data = $urandom; size = 2'($urandom);
    @(posedge mclk);                     // E1
    @(negedge mclk);
    chk("dv_low_after_E1", {31'b0, data_valid}, 32'h0);
    @(posedge mclk);                     // E2
    @(negedge mclk);
    chk("dv_high_after_E2", {31'b0, data_valid}, 32'h1);
    rd_got = read_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge mclk);
      @(negedge mclk);
      chk("hold_dv", {31'b0, data_valid}, 32'h1);
      chk("hold_rd_stable", read_data, rd_got);
    end
    rw_req = 1'b0;
    @(posedge mclk);                     // Ek
    @(negedge mclk);
    chk("dv_low_after_drop", {31'b0, data_valid}, 32'h0);
    chk("port_state", {31'b0, port}, {31'b0, m_port});
  endtask

  logic [31:0] rd;
  logic        w_r;
  logic [1:0]  sz_r;
  logic [31:0] a_r;
  int          sel;

  initial begin
    reset = 1'b0; rw_req = 1'b0; rw = 1'b0; size = 2'd0;
    address = 32'h0; write_data = 32'h0;
    m_port = 1'b0; m_last_rd = 32'h0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk("reset_dv", {31'b0, data_valid}, 32'h0);
    chk("reset_rd", read_data, 32'h0);
    chk("reset_port", {31'b0, port}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    reset = 1'b1;

    // Prefill the random window so every model byte there is defined.
    for (int i = 0; i < 256; i++) do_txn(1'b1, 2'd2, 32'(4 * i), $urandom, 0, rd);

    // Word write/read.
    do_txn(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 0, rd);
    do_txn(1'b0, 2'd2, 32'h100, 32'h0, 0, rd);
    chk("lw_100", rd, 32'hDEADBEEF);

    // Byte lanes.
    do_txn(1'b1, 2'd2, 32'h200, 32'h11223344, 0, rd);
    do_txn(1'b1, 2'd0, 32'h202, 32'h000000AA, 0, rd);
    do_txn(1'b0, 2'd2, 32'h200, 32'h0, 0, rd);
    chk("lw_200", rd, 32'h11AA3344);
    do_txn(1'b0, 2'd0, 32'h203, 32'h0, 0, rd);
    chk("lb_203", rd, 32'h00000011);
    do_txn(1'b0, 2'd1, 32'h202, 32'h0, 0, rd);
    chk("lh_202", rd, 32'h000011AA);

    // Port register and unmapped space.
    do_txn(1'b1, 2'd2, PORT_A, 32'h1, 0, rd);
    chk("port_set", {31'b0, port}, 32'h1);
    do_txn(1'b0, 2'd2, PORT_A, 32'h0, 0, rd);
    chk("lw_port", rd, 32'h1);
    do_txn(1'b1, 2'd0, PORT_A, 32'h0, 0, rd);
    chk("port_clr", {31'b0, port}, 32'h0);
    do_txn(1'b1, 2'd2, 32'h1000, 32'h0, 0, rd);
    do_txn(1'b1, 2'd2, 32'h3000, 32'hFFFFFFFF, 0, rd);
    chk("port_unmapped", {31'b0, port}, 32'h0);
    do_txn(1'b0, 2'd2, 32'h3000, 32'h0, 0, rd);
    chk("lw_3000", rd, 32'h0);
    do_txn(1'b0, 2'd2, 32'h1000, 32'h0, 0, rd);
    chk("no_alias_1000", rd, 32'h0);

    // Handshake hold, then immediate new transaction.
    do_txn(1'b0, 2'd2, 32'h100, 32'h0, 10, rd);
    chk("hold_lw", rd, 32'hDEADBEEF);
    do_txn(1'b0, 2'd0, 32'h100, 32'h0, 0, rd);
    chk("after_hold_lb", rd, 32'h000000EF);

    // Misaligned accesses.
    do_txn(1'b0, 2'd2, 32'h102, 32'h0, 0, rd);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    chk("lw_102_misal", rd, 32'h0);
`else
    chk("lw_102_trunc", rd, 32'hDEADBEEF);
`endif
    do_txn(1'b1, 2'd1, 32'h101, 32'h00001234, 0, rd);
    do_txn(1'b0, 2'd2, 32'h100, 32'h0, 0, rd);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    chk("sh_101_dropped", rd, 32'hDEADBEEF);
`else
    chk("sh_101_trunc", rd, 32'hDEAD1234);
`endif

    // Reset during the ACCESS edge of a store.
    do_txn(1'b1, 2'd2, PORT_A, 32'h1, 0, rd);
    do_txn(1'b1, 2'd2, 32'h40, 32'h0, 0, rd);
    rw_req = 1'b1; rw = 1'b1; size = 2'd2; address = 32'h40; write_data = 32'h55;
    @(posedge mclk);                     // E0
    @(negedge mclk);
    reset = 1'b0;
    @(posedge mclk);                     // ACCESS edge under reset
    @(negedge mclk);
    chk("rst_mid_dv", {31'b0, data_valid}, 32'h0);
    chk("rst_mid_port", {31'b0, port}, 32'h0);
    chk("rst_mid_err", {31'b0, err}, 32'h0);
    chk("rst_mid_rd", read_data, 32'h0);
    rw_req = 1'b0;
    @(posedge mclk);
    @(negedge mclk);
    reset = 1'b1;
    m_port = 1'b0;
    m_last_rd = 32'h0;
    do_txn(1'b0, 2'd2, 32'h40, 32'h0, 0, rd);
    chk("lw_40_after_rst", rd, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      sel  = $urandom_range(0, 9);
      w_r  = 1'($urandom);
      sz_r = 2'($urandom);
      if (sel < 8)       a_r = 32'($urandom_range(0, 1023));
      else if (sel == 8) a_r = PORT_A;
      else               a_r = 32'h3000 + 32'($urandom_range(0, 255));
      do_txn(w_r, sz_r, a_r, $urandom, $urandom_range(0, 3), rd);
    end

    repeat (2) @(negedge mclk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
